ipv4_addr_extractor: RTL and testbench

Parses the 1G receive byte stream and pulls the IPv4 source and destination addresses out of each frame. It then issues one look-up request (destination) and one insert request (source) to the IP hash controller. It sits directly upstream of the hash controller and drives its `insert_val_i`, `look_up_val_i` and `ip_addr_i` inputs. Frames that are not IPv4 are skipped. Malformed IPv4 frames are dropped and counted.

---
 rtl/ipv4_addr_extractor.sv | 152 +++++++++++++++
 tb/tb_ipv4_addr_extractor.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_addr_extractor.sv
// Extracts IPv4 source/destination addresses from a 1G receive byte stream and
// issues one look-up (destination) followed by one insert (source) per IPv4 frame.
module ipv4_addr_extractor #(
  parameter int IP_ADDR_W = 32,
  parameter int DATA_W    = 8,
  parameter int VLAN_EN   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 valid_i,
  input  logic                 sop_i,
  input  logic                 eop_i,
  output logic                 look_up_val_o,
  output logic                 insert_val_o,
  output logic [IP_ADDR_W-1:0] ip_addr_o,
  output logic [CNT_W-1:0]     drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, HDR, DRAIN} state_t;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_VLAN = 16'h8100;

  state_t               state_reg, state_next;
  logic [5:0]           byte_idx_reg, byte_idx_next;
  logic [7:0]           etype_hi_reg, etype_hi_next;
  logic                 vlan_reg, vlan_next;
  logic                 ip_known_reg, ip_known_next;
  logic [5:0]           base_reg, base_next;
  logic [IP_ADDR_W-1:0] src_reg, src_next;
  logic [IP_ADDR_W-1:0] dst_reg, dst_next;
  logic [5:0]           rel;
  logic [15:0]          etype;
  logic                 capture_evt;
  logic                 drop_evt;

  // Offset of the current byte from the start of the IPv4 header.
  assign rel   = byte_idx_reg - base_reg;
  assign etype = {etype_hi_reg, data_i};

  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    etype_hi_next = etype_hi_reg;
    vlan_next     = vlan_reg;
    ip_known_next = ip_known_reg;
    base_next     = base_reg;
    src_next      = src_reg;
    dst_next      = dst_reg;
    capture_evt   = 1'b0;
    drop_evt      = 1'b0;

    if (valid_i) begin
      if (sop_i) begin
        byte_idx_next = 6'd1;
        vlan_next     = 1'b0;
        ip_known_next = 1'b0;
        if (eop_i) begin
          drop_evt   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = HDR;
        end
      end else if (state_reg != IDLE) begin
        if (byte_idx_reg != 6'd63)
          byte_idx_next = byte_idx_reg + 6'd1;

        if (state_reg == HDR) begin
          if (!ip_known_reg) begin
            if (byte_idx_reg == 6'd12 || byte_idx_reg == 6'd16)
              etype_hi_next = data_i;
            if (byte_idx_reg == 6'd13 || (vlan_reg && byte_idx_reg == 6'd17)) begin
              if (etype == ETH_IPV4) begin
                ip_known_next = 1'b1;
                base_next     = byte_idx_reg + 6'd1;
              end else if (VLAN_EN != 0 && !vlan_reg && etype == ETH_VLAN) begin
                vlan_next = 1'b1;
              end else begin
                state_next = DRAIN;
              end
            end
          end else if (rel == 6'd0 && (data_i[7:4] != 4'h4 || data_i[3:0] < 4'd5)) begin
            drop_evt   = 1'b1;
            state_next = DRAIN;
          end else begin
            if (rel >= 6'd12 && rel <= 6'd15)
              src_next = {src_reg[IP_ADDR_W-DATA_W-1:0], data_i};
            if (rel >= 6'd16 && rel <= 6'd19)
              dst_next = {dst_reg[IP_ADDR_W-DATA_W-1:0], data_i};
            if (rel == 6'd19) begin
              capture_evt = 1'b1;
              state_next  = DRAIN;
            end
          end

          // A recognised IPv4 frame ending before its destination address is malformed.
          if (eop_i) begin
            state_next = IDLE;
            if (ip_known_next && !capture_evt && !drop_evt)
              drop_evt = 1'b1;
          end
        end else if (eop_i) begin
          state_next = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      etype_hi_reg <= '0;
      vlan_reg     <= 1'b0;
      ip_known_reg <= 1'b0;
      base_reg     <= '0;
      src_reg      <= '0;
      dst_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      etype_hi_reg <= etype_hi_next;
      vlan_reg     <= vlan_next;
      ip_known_reg <= ip_known_next;
      base_reg     <= base_next;
      src_reg      <= src_next;
      dst_reg      <= dst_next;
    end
  end

  // Two-stage emission: destination look-up, then source insert on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      look_up_val_o <= 1'b0;
      insert_val_o  <= 1'b0;
      ip_addr_o     <= '0;
      drop_cnt_o    <= '0;
    end else begin
      look_up_val_o <= capture_evt;
      insert_val_o  <= look_up_val_o;
      if (capture_evt)
        ip_addr_o <= dst_next;
      else if (look_up_val_o)
        ip_addr_o <= src_reg;
      if (drop_evt && drop_cnt_o != '1)
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_ipv4_addr_extractor.sv
// Randomised scoreboard bench for ipv4_addr_extractor: a frame-level reference model
// predicts emissions and drops; a monitor checks every cycle's outputs.
module tb_ipv4_addr_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        sop_i = 1'b0;
  logic        eop_i = 1'b0;
  logic        look_up_val_o, insert_val_o;
  logic [31:0] ip_addr_o;
  logic [15:0] drop_cnt_o;
  logic        lu2, ins2;
  logic [31:0] ip2;
  logic [1:0]  drop2;

  always #5 clk = ~clk;

  ipv4_addr_extractor u_dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i),
    .look_up_val_o(look_up_val_o), .insert_val_o(insert_val_o),
    .ip_addr_o(ip_addr_o), .drop_cnt_o(drop_cnt_o)
  );

  ipv4_addr_extractor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i),
    .look_up_val_o(lu2), .insert_val_o(ins2), .ip_addr_o(ip2), .drop_cnt_o(drop2)
  );

  typedef struct {
    bit          ins;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  frm[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          exp_drop = 0;
  logic        rst_q = 1'b1;
  logic        mon_en = 1'b0;
  logic [31:0] exp_hold = '0;
  logic        e_lu, e_ins;
  exp_t        m_ent;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard when a pulse is due, otherwise expects silence and a held address.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        sb.delete();
        exp_hold = '0;
      end
      e_lu  = 1'b0;
      e_ins = 1'b0;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        m_ent    = sb.pop_front();
        e_lu     = !m_ent.ins;
        e_ins    = m_ent.ins;
        exp_hold = m_ent.addr;
      end
      chk("look_up",    32'(look_up_val_o), 32'(e_lu));
      chk("insert",     32'(insert_val_o),  32'(e_ins));
      chk("ip_addr",    ip_addr_o,          exp_hold);
      chk("look_up_w2", 32'(lu2),           32'(e_lu));
      chk("insert_w2",  32'(ins2),          32'(e_ins));
      chk("ip_addr_w2", ip2,                exp_hold);
    end
  end

  // Reference model: outcome of delivering the first n bytes of frm (with or without eop).
  function automatic void classify(input int n, input bit eop, output int emit_idx, output bit drop);
    int         b;
    logic [15:0] et;
    logic [7:0] vb;
    emit_idx = -1;
    drop     = 1'b0;
    if (n == 1 && eop) begin
      drop = 1'b1;
      return;
    end
    if (n < 14) return;
    et = {frm[12], frm[13]};
    if (et == 16'h0800) begin
      b = 14;
    end else if (et == 16'h8100) begin
      if (n < 18) return;
      et = {frm[16], frm[17]};
      if (et != 16'h0800) return;
      b = 18;
    end else begin
      return;
    end
    if (n > b) begin
      vb = frm[b];
      if (vb[7:4] != 4'h4 || vb[3:0] < 4'd5) begin
        drop = 1'b1;
        return;
      end
    end
    if (n >= b + 20) emit_idx = b + 19;
    else if (eop) drop = 1'b1;
  endfunction

  // kind: 0 IPv4, 1 VLAN IPv4, 2 ARP, 3 VLAN non-IP, 4 bad version, 5 bad IHL
  task automatic build_frame(input int kind, input int len, input logic [31:0] src, input logic [31:0] dst);
    int b;
    int v;
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    b = (kind == 1 || kind == 3) ? 18 : 14;
    frm[12] = (b == 18) ? 8'h81 : 8'h08;
    frm[13] = (kind == 2) ? 8'h06 : 8'h00;
    if (b == 18) begin
      frm[16] = (kind == 3) ? 8'h86 : 8'h08;
      frm[17] = (kind == 3) ? 8'hDD : 8'h00;
    end
    if (b < len) begin
      if (kind == 4) begin
        v = $urandom_range(0, 14);
        if (v >= 4) v++;
        frm[b] = {v[3:0], 4'h5};
      end else if (kind == 5) begin
        frm[b] = {4'h4, 4'($urandom_range(0, 4))};
      end else begin
        frm[b] = {4'h4, 4'($urandom_range(5, 15))};
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (b + 12 + k < len) frm[b + 12 + k] = src[31 - 8*k -: 8];
      if (b + 16 + k < len) frm[b + 16 + k] = dst[31 - 8*k -: 8];
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      valid_i = 1'b0;
      data_i  = 8'($urandom);
      sop_i   = 1'($urandom);
      eop_i   = 1'($urandom);
      @(posedge clk); #1;
    end
    sop_i = 1'b0;
    eop_i = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit with_eop, input bit gaps);
    int   eidx;
    bit   drp;
    int   b;
    exp_t e;
    classify(n, with_eop, eidx, drp);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      valid_i = 1'b1;
      data_i  = frm[i];
      sop_i   = (i == 0);
      eop_i   = with_eop && (i == n - 1);
      if (i == eidx) begin
        b      = eidx - 19;
        e.ins  = 1'b0;
        e.addr = {frm[b+16], frm[b+17], frm[b+18], frm[b+19]};
        e.cyc  = cyc + 1;
        sb.push_back(e);
        e.ins  = 1'b1;
        e.addr = {frm[b+12], frm[b+13], frm[b+14], frm[b+15]};
        e.cyc  = cyc + 2;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
    if (drp) exp_drop++;
  endtask

  task automatic check_drop(input string tag);
    chk({tag, "_drop"},    32'(drop_cnt_o), 32'(exp_drop));
    chk({tag, "_drop_w2"}, 32'(drop2),      (exp_drop > 3) ? 32'd3 : 32'(exp_drop));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    exp_drop = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int kind, mode, b, len, n;
    bit g;

    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_look_up", 32'(look_up_val_o), 32'd0);
    chk("rst_insert",  32'(insert_val_o),  32'd0);
    chk("rst_ip_addr", ip_addr_o,          32'd0);
    check_drop("rst");

    // Untagged IPv4, no gaps
    build_frame(0, 64, 32'h0A000001, 32'hC0A80105);
    frm[14] = 8'h45;
    send_frame(64, 1, 0);
    idle_cycles(6);
    check_drop("ipv4");

    // VLAN tagged, gaps
    build_frame(1, 64, 32'h0A000001, 32'hC0A80105);
    send_frame(64, 1, 1);
    idle_cycles(4);
    check_drop("vlan");

    // ARP then 20-byte truncated IPv4
    build_frame(2, 64, 32'h01020304, 32'h05060708);
    send_frame(64, 1, 0);
    check_drop("arp");
    build_frame(0, 20, 32'h01020304, 32'h05060708);
    send_frame(20, 1, 0);
    idle_cycles(1);
    check_drop("trunc");

    // Version 6 header, then a 1-byte runt
    build_frame(0, 64, 32'h11111111, 32'h22222222);
    frm[14] = 8'h65;
    send_frame(64, 1, 0);
    check_drop("ver6");
    build_frame(0, 64, 32'h11111111, 32'h22222222);
    send_frame(1, 1, 0);
    idle_cycles(1);
    check_drop("runt");

    // Restart at byte 20, then a complete frame
    build_frame(0, 64, 32'hDEAD0001, 32'hBEEF0002);
    send_frame(20, 0, 0);
    build_frame(0, 64, 32'hAC100001, 32'hAC100002);
    send_frame(64, 1, 0);
    idle_cycles(3);
    check_drop("restart");

    // Reset on the capture byte: nothing is emitted, and the frame tail without sop is ignored
    build_frame(0, 64, 32'h33333333, 32'h44444444);
    send_frame(33, 0, 0);
    rst     = 1'b1;
    valid_i = 1'b1;
    data_i  = frm[33];
    @(posedge clk); #1;
    rst      = 1'b0;
    exp_drop = 0;
    for (int i = 34; i < 64; i++) begin
      valid_i = 1'b1;
      data_i  = frm[i];
      eop_i   = (i == 63);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    eop_i   = 1'b0;
    idle_cycles(3);
    check_drop("rst_cap");

    // Reset while the look-up pulse is out: insert is suppressed
    build_frame(0, 64, 32'h55555555, 32'h66666666);
    send_frame(34, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(3);
    chk("rst_emit_addr", ip_addr_o, 32'd0);

    // Counter saturation
    do_reset();
    for (int r = 0; r < 5; r++) begin
      build_frame(0, 64, 32'h0, 32'h0);
      send_frame(1, 1, 0);
      idle_cycles(1);
      check_drop("sat");
    end

    // Randomised frames
    do_reset();
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 5);
      b    = (kind == 1 || kind == 3) ? 18 : 14;
      mode = $urandom_range(0, 9);
      g    = 1'($urandom);
      if (mode <= 5) begin
        len = $urandom_range(b + 20, 80);
        build_frame(kind, len, $urandom, $urandom);
        send_frame(len, 1, g);
      end else if (mode == 6) begin
        len = $urandom_range(b + 1, b + 19);
        build_frame(kind, len, $urandom, $urandom);
        send_frame(len, 1, g);
      end else if (mode == 7) begin
        build_frame(kind, 64, $urandom, $urandom);
        send_frame(1, 1, g);
      end else if (mode == 8) begin
        build_frame(kind, 80, $urandom, $urandom);
        n = $urandom_range(2, 70);
        send_frame(n, 0, g);
      end else begin
        len = b + 20;
        build_frame(kind, len, $urandom, $urandom);
        send_frame(len, 1, g);
      end
      idle_cycles($urandom_range(0, 2));
      check_drop("rand");
    end

    idle_cycles(10);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
